// File: rtl/demux_pkg.sv
// Shared types and helpers for the 1-to-3 registered demultiplexer.
package demux_pkg;

  typedef enum logic [1:0] {
    CH0    = 2'd0,
    CH1    = 2'd1,
    CH2    = 2'd2,
    CH_BAD = 2'd3
  } chan_sel_t;

  localparam int unsigned NUM_CH = 3;

  // Round-robin successor; the pointer never holds CH_BAD.
  function automatic chan_sel_t rr_next(input chan_sel_t p);
    return (p == CH2) ? CH0 : chan_sel_t'(p + 2'd1);
  endfunction

endpackage

// File: rtl/demux_chan_buf.sv
// One-entry valid/ready output buffer; accepts a refill in the same cycle it drains.
module demux_chan_buf #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             can_wr
);

  assign can_wr = !valid || rd_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (wr_en) begin
      valid <= 1'b1;
      data  <= wr_data;
    end else if (rd_ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux1_3_buf.sv
// Registered 1-to-3 demultiplexer: explicit or round-robin routing into three
// buffered channels, with a saturating count of words dropped on select 3.
module demux1_3_buf
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             s0,
  input  logic             s1,
  input  logic             rr_en,
  output logic [WIDTH-1:0] o0_data,
  output logic [WIDTH-1:0] o1_data,
  output logic [WIDTH-1:0] o2_data,
  output logic             o0_valid,
  output logic             o1_valid,
  output logic             o2_valid,
  input  logic             o0_ready,
  input  logic             o1_ready,
  input  logic             o2_ready,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             err
);

  chan_sel_t         sel;
  chan_sel_t         tgt;
  chan_sel_t         rr_ptr;
  logic [NUM_CH-1:0] can_wr;
  logic [NUM_CH-1:0] wr_en;
  logic [NUM_CH-1:0] ch_valid;
  logic [NUM_CH-1:0] ch_ready;
  logic [WIDTH-1:0]  ch_data [NUM_CH];
  logic              accept;
  logic              drop;

  assign sel      = chan_sel_t'({s1, s0});
  assign tgt      = rr_en ? rr_ptr : sel;
  assign ch_ready = {o2_ready, o1_ready, o0_ready};

  always_comb begin
    in_ready = 1'b1;
    wr_en    = '0;
    drop     = 1'b0;
    accept   = 1'b0;
    case (tgt)
      CH0: begin
        in_ready = can_wr[0];
        accept   = in_valid && in_ready;
        wr_en[0] = accept;
      end
      CH1: begin
        in_ready = can_wr[1];
        accept   = in_valid && in_ready;
        wr_en[1] = accept;
      end
      CH2: begin
        in_ready = can_wr[2];
        accept   = in_valid && in_ready;
        wr_en[2] = accept;
      end
      default: begin
        accept = in_valid;
        drop   = in_valid;
      end
    endcase
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    demux_chan_buf #(.WIDTH(WIDTH)) u_buf (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (wr_en[i]),
      .wr_data  (in_data),
      .rd_ready (ch_ready[i]),
      .valid    (ch_valid[i]),
      .data     (ch_data[i]),
      .can_wr   (can_wr[i])
    );
  end

  assign o0_data  = ch_data[0];
  assign o1_data  = ch_data[1];
  assign o2_data  = ch_data[2];
  assign o0_valid = ch_valid[0];
  assign o1_valid = ch_valid[1];
  assign o2_valid = ch_valid[2];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr   <= CH0;
      drop_cnt <= '0;
      err      <= 1'b0;
    end else begin
      err <= drop;
      if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      // Only an accepted word moves the pointer, so stalls never skip a channel.
      if (accept && rr_en) rr_ptr <= rr_next(rr_ptr);
    end
  end

endmodule

// File: tb/tb_demux1_3_buf.sv
// Directed table-driven bench for demux1_3_buf plus hand sequences for
// reset, drop-counter saturation and mid-operation reset.
module tb_demux1_3_buf;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       s0, s1, rr_en;
  logic [7:0] o0_data, o1_data, o2_data;
  logic       o0_valid, o1_valid, o2_valid;
  logic       o0_ready, o1_ready, o2_ready;
  logic [7:0] drop_cnt;
  logic       err;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  demux1_3_buf #(.WIDTH(8), .CNT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .s0       (s0),
    .s1       (s1),
    .rr_en    (rr_en),
    .o0_data  (o0_data),
    .o1_data  (o1_data),
    .o2_data  (o2_data),
    .o0_valid (o0_valid),
    .o1_valid (o1_valid),
    .o2_valid (o2_valid),
    .o0_ready (o0_ready),
    .o1_ready (o1_ready),
    .o2_ready (o2_ready),
    .drop_cnt (drop_cnt),
    .err      (err)
  );

  typedef struct {
    logic       rr;
    logic [1:0] sel;
    logic       v;
    logic [7:0] d;
    logic [2:0] rdy;    // {o2,o1,o0}_ready
    logic       e_ir;   // in_ready before the edge
    logic [2:0] e_val;  // {o2,o1,o0}_valid after the edge
    logic [7:0] e_d0, e_d1, e_d2;
    logic       e_err;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t tbl [23];

  function automatic vec_t mk(input logic rr, input logic [1:0] sel, input logic v,
                              input logic [7:0] d, input logic [2:0] rdy, input logic e_ir,
                              input logic [2:0] e_val, input logic [7:0] e_d0,
                              input logic [7:0] e_d1, input logic [7:0] e_d2,
                              input logic e_err, input logic [7:0] e_cnt);
    vec_t t;
    t.rr = rr; t.sel = sel; t.v = v; t.d = d; t.rdy = rdy; t.e_ir = e_ir;
    t.e_val = e_val; t.e_d0 = e_d0; t.e_d1 = e_d1; t.e_d2 = e_d2;
    t.e_err = e_err; t.e_cnt = e_cnt;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rr, input logic [1:0] sel, input logic v,
                       input logic [7:0] d, input logic [2:0] rdy);
    rr_en    = rr;
    {s1, s0} = sel;
    in_valid = v;
    in_data  = d;
    {o2_ready, o1_ready, o0_ready} = rdy;
  endtask

  function automatic logic [2:0] valids();
    return {o2_valid, o1_valid, o0_valid};
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: got stuck want finish");
    $fatal(1, "timeout");
  end

  initial begin
    //                rr sel v  d      rdy    ir  val    d0     d1     d2     err cnt
    // explicit routing
    tbl[0]  = mk(1'b0, 2'd0, 1, 8'h11, 3'b111, 1, 3'b001, 8'h11, 8'h00, 8'h00, 0, 8'd0);
    tbl[1]  = mk(1'b0, 2'd1, 1, 8'h22, 3'b111, 1, 3'b010, 8'h00, 8'h22, 8'h00, 0, 8'd0);
    tbl[2]  = mk(1'b0, 2'd2, 1, 8'h33, 3'b111, 1, 3'b100, 8'h00, 8'h00, 8'h33, 0, 8'd0);
    tbl[3]  = mk(1'b0, 2'd0, 0, 8'h00, 3'b111, 1, 3'b000, 8'h00, 8'h00, 8'h00, 0, 8'd0);
    // backpressure on ch1, ch0 stays open, pass-through refill
    tbl[4]  = mk(1'b0, 2'd1, 1, 8'hA1, 3'b101, 1, 3'b010, 8'h00, 8'hA1, 8'h00, 0, 8'd0);
    tbl[5]  = mk(1'b0, 2'd1, 1, 8'hA2, 3'b101, 0, 3'b010, 8'h00, 8'hA1, 8'h00, 0, 8'd0);
    tbl[6]  = mk(1'b0, 2'd0, 1, 8'hB0, 3'b101, 1, 3'b011, 8'hB0, 8'hA1, 8'h00, 0, 8'd0);
    tbl[7]  = mk(1'b0, 2'd1, 1, 8'hA2, 3'b111, 1, 3'b010, 8'h00, 8'hA2, 8'h00, 0, 8'd0);
    tbl[8]  = mk(1'b0, 2'd0, 0, 8'h00, 3'b111, 1, 3'b000, 8'h00, 8'h00, 8'h00, 0, 8'd0);
    // round robin with ch2 stalled holding 0x03
    tbl[9]  = mk(1'b1, 2'd0, 1, 8'h01, 3'b111, 1, 3'b001, 8'h01, 8'h00, 8'h00, 0, 8'd0);
    tbl[10] = mk(1'b1, 2'd0, 1, 8'h02, 3'b011, 1, 3'b010, 8'h00, 8'h02, 8'h00, 0, 8'd0);
    tbl[11] = mk(1'b1, 2'd0, 1, 8'h03, 3'b011, 1, 3'b100, 8'h00, 8'h00, 8'h03, 0, 8'd0);
    tbl[12] = mk(1'b1, 2'd0, 1, 8'h04, 3'b011, 1, 3'b101, 8'h04, 8'h00, 8'h03, 0, 8'd0);
    tbl[13] = mk(1'b1, 2'd0, 1, 8'h05, 3'b011, 1, 3'b110, 8'h00, 8'h05, 8'h03, 0, 8'd0);
    tbl[14] = mk(1'b1, 2'd0, 1, 8'h06, 3'b011, 0, 3'b100, 8'h00, 8'h00, 8'h03, 0, 8'd0);
    tbl[15] = mk(1'b1, 2'd0, 1, 8'h06, 3'b011, 0, 3'b100, 8'h00, 8'h00, 8'h03, 0, 8'd0);
    tbl[16] = mk(1'b1, 2'd0, 1, 8'h06, 3'b111, 1, 3'b100, 8'h00, 8'h00, 8'h06, 0, 8'd0);
    tbl[17] = mk(1'b1, 2'd0, 0, 8'h00, 3'b111, 1, 3'b000, 8'h00, 8'h00, 8'h00, 0, 8'd0);
    // pointer holds while rr_en=0; select ignored while rr_en=1
    tbl[18] = mk(1'b0, 2'd1, 1, 8'h77, 3'b111, 1, 3'b010, 8'h00, 8'h77, 8'h00, 0, 8'd0);
    tbl[19] = mk(1'b1, 2'd2, 1, 8'h88, 3'b111, 1, 3'b001, 8'h88, 8'h00, 8'h00, 0, 8'd0);
    tbl[20] = mk(1'b1, 2'd3, 1, 8'h99, 3'b111, 1, 3'b010, 8'h00, 8'h99, 8'h00, 0, 8'd0);
    // single discard, then err falls back
    tbl[21] = mk(1'b0, 2'd3, 1, 8'h55, 3'b111, 1, 3'b000, 8'h00, 8'h00, 8'h00, 1, 8'd1);
    tbl[22] = mk(1'b0, 2'd0, 0, 8'h00, 3'b111, 1, 3'b000, 8'h00, 8'h00, 8'h00, 0, 8'd1);

    // reset held 2 clks with a word offered
    rst_n = 1'b0;
    drive(1'b0, 2'd0, 1'b1, 8'h5A, 3'b111);
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(valids()), 32'd0);
    check("rst_data0", 32'(o0_data), 32'd0);
    check("rst_cnt", 32'(drop_cnt), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 2'd0, 1'b0, 8'h00, 3'b111);

    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      drive(tbl[i].rr, tbl[i].sel, tbl[i].v, tbl[i].d, tbl[i].rdy);
      #1;
      check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_valid", i), 32'(valids()), 32'(tbl[i].e_val));
      if (tbl[i].e_val[0]) check($sformatf("v%0d_o0", i), 32'(o0_data), 32'(tbl[i].e_d0));
      if (tbl[i].e_val[1]) check($sformatf("v%0d_o1", i), 32'(o1_data), 32'(tbl[i].e_d1));
      if (tbl[i].e_val[2]) check($sformatf("v%0d_o2", i), 32'(o2_data), 32'(tbl[i].e_d2));
      check($sformatf("v%0d_err", i), 32'(err), 32'(tbl[i].e_err));
      check($sformatf("v%0d_cnt", i), 32'(drop_cnt), 32'(tbl[i].e_cnt));
    end

    // 300 discards: err each cycle, no channel activity, counter saturates
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      drive(1'b0, 2'd3, 1'b1, 8'(k), 3'b111);
      #1;
      check("drop_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      check("drop_err", 32'(err), 32'd1);
      check("drop_valid", 32'(valids()), 32'd0);
      check("drop_cnt", 32'(drop_cnt), (k + 2 > 255) ? 32'd255 : 32'(k + 2));
    end
    @(negedge clk);
    drive(1'b0, 2'd0, 1'b0, 8'h00, 3'b111);
    @(posedge clk);
    #1;
    check("drop_err_idle", 32'(err), 32'd0);
    check("drop_cnt_sat", 32'(drop_cnt), 32'd255);

    // fill all three channels with consumers stalled (rr pointer now at ch2)
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive(1'b0, 2'(c), 1'b1, 8'hC0 + 8'(c), 3'b000);
      @(posedge clk);
    end
    #1;
    check("full_valid", 32'(valids()), 32'h7);
    check("full_o2", 32'(o2_data), 32'hC2);
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b1, 2'd0, 1'b0, 8'h00, 3'b000);
    @(posedge clk);
    #1;
    check("mrst_valid", 32'(valids()), 32'd0);
    check("mrst_cnt", 32'(drop_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 2'd2, 1'b1, 8'hD0, 3'b000);
    #1;
    check("mrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    check("mrst_rr_valid", 32'(valids()), 32'h1);
    check("mrst_rr_o0", 32'(o0_data), 32'hD0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux1_3_buf.md
Name: demux1_3_buf

Overview:
- Registered 1-to-3 demultiplexer; the distribution-side counterpart of the team's 3:1 select mux.
- Routes each accepted input word to one of three output channels. Routing follows an explicit select, or an internal round-robin pointer.
- Each channel holds its word in a one-entry buffer with a valid/ready handshake, so a stalled channel blocks only writes aimed at it.
- Sits between a shared source bus and three independent consumers.

Parameters:
- WIDTH, 8, data width of input and every channel.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_data  input  WIDTH  input word.
- in_valid  input  1  input word present.
- in_ready  output  1  block accepts the word this cycle.
- s0  input  1  select bit 0.
- s1  input  1  select bit 1; sel = {s1,s0}.
- rr_en  input  1  1 = ignore s1/s0 and use the round-robin pointer.
- o0_data, o1_data, o2_data  output  WIDTH  channel data.
- o0_valid, o1_valid, o2_valid  output  1  channel holds a word.
- o0_ready, o1_ready, o2_ready  input  1  consumer takes the word.
- drop_cnt  output  CNT_W  count of words discarded on sel=3.
- err  output  1  one-cycle pulse on each discard.

Behaviour:
- Reset (rst_n=0 at a rising clk edge):
  - all oN_valid=0, oN_data=0, drop_cnt=0, err=0.
  - rr pointer=0.
  - in_ready is combinational, so it is 0 only when the target channel is full; after reset it is 1.
- Target channel:
  - rr_en=1: tgt = rr pointer.
  - rr_en=0: sel 0→ch0, 1→ch1, 2→ch2, 3→invalid.
- in_ready:
  - 1 when the target buffer is empty, or when it is full and its consumer asserts ready in the same cycle (pass-through refill).
  - Always 1 for sel=3.
  - Combinational from the buffer state and oN_ready; no combinational path from in_data.
- Accept = in_valid & in_ready.
- On accept with a valid target:
  - word is registered into that channel.
  - oN_valid=1 on the next cycle; latency is exactly 1 clk.
- On accept with sel=3 (rr_en=0):
  - word is discarded; no channel changes.
  - err=1 for one cycle (registered, the cycle after accept).
  - drop_cnt increments and saturates at all-ones.
- Channel buffer:
  - clears when oN_valid & oN_ready and no refill arrives.
  - simultaneous drain and refill leaves valid=1 with the new data.
  - data holds stable while valid & !ready.
- Round-robin pointer:
  - advances 0→1→2→0 only on accept while rr_en=1.
  - a stall (in_ready=0) does not advance it.
  - holds its value while rr_en=0, and resumes from that value when rr_en returns to 1.
- rr_en or sel may change any cycle; they take effect combinationally for that cycle's routing.
- Reset mid-operation discards buffered words: valid drops in the cycle after the reset edge, and no partial word is emitted.
- Channels are independent: ch1 full and stalled does not block accepts to ch0 or ch2.

Decomposition:
- Package demux_pkg holds:
  - typedef chan_sel_t, 2-bit, with values CH0=0, CH1=1, CH2=2, CH_BAD=3.
  - constant NUM_CH=3.
  - rr-pointer wrap function.
- Sub-module demux_chan_buf: one-entry valid/ready buffer with parameter WIDTH and ports clk, rst_n, wr_en, wr_data, rd_ready, valid, data, can_wr. Instantiated three times.
- Top level holds target decode, rr pointer, drop counter and err.

Test Plan:
- Reset: hold rst_n=0 for 2 clks with in_valid=1 → all oN_valid=0, drop_cnt=0, err=0, in_ready=1.
- Explicit routing: rr_en=0, all readies=1; send 0x11 sel=0, 0x22 sel=1, 0x33 sel=2 on back-to-back cycles → o0=0x11, o1=0x22, o2=0x33, each valid exactly 1 clk after its accept.
- Backpressure and independence:
  - o1_ready=0; send 0xA1 then 0xA2 to sel=1 → 0xA1 held; in_ready=0 on 0xA2.
  - a word to sel=0 in the same window is accepted.
  - raising o1_ready lets 0xA2 be accepted that cycle; o1_data=0xA2 the next cycle.
- Round robin: rr_en=1; send 0x01..0x06, stalling ch2 for 3 clks at 0x03 → ch0 gets 0x01,0x04; ch1 gets 0x02,0x05; ch2 gets 0x03,0x06; pointer does not skip during the stall.
- Invalid select: rr_en=0, sel=3, send 300 words → err pulses on every one, no oN_valid change, drop_cnt saturates at 255.
- Mid-operation reset: all three channels full with readies=0; assert rst_n=0 for 1 clk → all valids=0 the next cycle; next rr accept goes to ch0.
